// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects a qualified serial bit stream into WIDTH-bit words behind a one-entry valid/ready holding register.
// Define PARITY_CHECK_EN to expect one trailing even-parity bit per frame and report parity_err.
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             align,
   input  logic             out_ready,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             overflow,
   output logic             parity_err
);
`ifdef PARITY_CHECK_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
   logic [CW-1:0]    r_cnt, w_cnt;
   logic [WIDTH-1:0] r_shift, r_out, w_base, w_shift, w_shreg, w_word;
   logic             r_valid, r_ovf, r_perr, w_done, w_load, w_perr;
   // align restarts the frame, so the current bit (if any) is framed against an empty word
   always_comb begin
      w_cnt   = align ? '0 : r_cnt;
      w_base  = align ? '0 : r_shift;
      w_shift = MSB_FIRST ? {w_base[WIDTH-2:0], serial_in} : {serial_in, w_base[WIDTH-1:1]};
      w_done  = serial_valid && (w_cnt == LAST);
      w_load  = w_done && (!r_valid || out_ready);
`ifdef PARITY_CHECK_EN
      w_shreg = w_done ? w_base : w_shift;
      w_word  = w_base;
      w_perr  = ^w_base ^ serial_in;
`else
      w_shreg = w_shift;
      w_word  = w_shift;
      w_perr  = 1'b0;
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         r_perr  <= 1'b0;
      end else begin
         if (serial_valid) begin
            r_cnt   <= w_done ? '0 : w_cnt + 1'b1;
            r_shift <= w_shreg;
         end else if (align) begin
            r_cnt   <= '0;
            r_shift <= '0;
         end
         if (w_load) begin
            r_out   <= w_word;
            r_perr  <= w_perr;
            r_valid <= 1'b1;
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
         // a drop beats a simultaneous clear
         if (w_done && !w_load) r_ovf <= 1'b1;
         else if (clr_ovf) r_ovf <= 1'b0;
      end
   end
   assign parallel_out = r_out;
   assign out_valid    = r_valid;
   assign overflow     = r_ovf;
   assign parity_err   = r_perr;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed checks of an MSB-first and an LSB-first instance sharing one stimulus stream.
module tb_sipo_deserializer;
   logic       clk = 1'b0, rst = 1'b1;
   logic       serial_in = 1'b0, serial_valid = 1'b0, align = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
   logic [3:0] po_m, po_l;
   logic       ov_m, ov_l, of_m, of_l, pe_m, pe_l;
   logic       pflip = 1'b0;
   int         n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid), .align(align),
      .out_ready(out_ready), .clr_ovf(clr_ovf), .parallel_out(po_m), .out_valid(ov_m),
      .overflow(of_m), .parity_err(pe_m));
   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid), .align(align),
      .out_ready(out_ready), .clr_ovf(clr_ovf), .parallel_out(po_l), .out_valid(ov_l),
      .overflow(of_l), .parity_err(pe_l));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic b);
      serial_in = b;
      serial_valid = 1'b1;
      tick;
      serial_valid = 1'b0;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick;
   endtask
   task automatic send_word(input logic [3:0] w, input logic rl, input logic cl);
      for (int i = 3; i > 0; i--) send(w[i]);
`ifdef PARITY_CHECK_EN
      send(w[0]);
      out_ready = rl;
      clr_ovf = cl;
      send(^w ^ pflip);
`else
      out_ready = rl;
      clr_ovf = cl;
      send(w[0]);
`endif
      out_ready = 1'b0;
      clr_ovf = 1'b0;
   endtask
   task automatic drain;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
   endtask
   task automatic parity_bit(input logic p);
`ifdef PARITY_CHECK_EN
      send(p);
`else
      if (p) idle(0);
`endif
   endtask
   initial begin
      idle(2);
      rst = 1'b0;
      chk("rst_po", po_m, 4'h0);
      chk("rst_valid", ov_m, 1'b0);
      chk("rst_ovf", of_m, 1'b0);
      chk("rst_perr", pe_m, 1'b0);
      // basic word, both bit orders
      send_word(4'b1011, 1'b0, 1'b0);
      chk("t1_po_msb", po_m, 4'b1011);
      chk("t1_valid", ov_m, 1'b1);
      chk("t1_ovf", of_m, 1'b0);
      chk("t2_po_lsb", po_l, 4'b1101);
      chk("t1_perr", pe_m, 1'b0);
      // drop under back-pressure
      send_word(4'b0110, 1'b0, 1'b0);
      chk("t3_po_held", po_m, 4'b1011);
      chk("t3_po_held_lsb", po_l, 4'b1101);
      chk("t3_ovf", of_m, 1'b1);
      chk("t3_valid", ov_m, 1'b1);
      send_word(4'b0001, 1'b0, 1'b1);
      chk("t3_set_beats_clr", of_m, 1'b1);
      chk("t3_po_held2", po_m, 4'b1011);
      drain;
      chk("t3_accept", ov_m, 1'b0);
      chk("t3_ovf_sticky", of_m, 1'b1);
      clr_ovf = 1'b1;
      tick;
      clr_ovf = 1'b0;
      chk("t3_clr", of_m, 1'b0);
      // back-to-back with accept on the completion edge
      send_word(4'b1011, 1'b0, 1'b0);
      chk("t4_first", po_m, 4'b1011);
      send_word(4'b0110, 1'b1, 1'b0);
      chk("t4_valid", ov_m, 1'b1);
      chk("t4_po", po_m, 4'b0110);
      chk("t4_po_lsb", po_l, 4'b0110);
      chk("t4_ovf", of_m, 1'b0);
      drain;
      chk("t4_drained", ov_m, 1'b0);
      // align with a bit on the same edge
      send(1'b1);
      send(1'b1);
      serial_in = 1'b0;
      serial_valid = 1'b1;
      align = 1'b1;
      tick;
      serial_valid = 1'b0;
      align = 1'b0;
      chk("t5_no_early", ov_m, 1'b0);
      send(1'b1);
      send(1'b1);
      send(1'b0);
      parity_bit(1'b0);
      chk("t5_po", po_m, 4'b0110);
      chk("t5_po_lsb", po_l, 4'b0110);
      chk("t5_valid", ov_m, 1'b1);
      drain;
      // align alone discards a partial word
      send(1'b1);
      send(1'b0);
      align = 1'b1;
      tick;
      align = 1'b0;
      send_word(4'b1001, 1'b0, 1'b0);
      chk("t5_align_only", po_m, 4'b1001);
      chk("t5_align_only_lsb", po_l, 4'b1001);
      drain;
      // idle gaps between bits
      for (int g = 0; g < 4; g++) begin
         send(1'b0);
         idle(g);
         send(1'b1);
         idle(g);
         send(1'b1);
         idle(g);
         chk("t5_gap_pending", ov_m, 1'b0);
         send(1'b0);
         parity_bit(1'b0);
         chk($sformatf("t5_gap%0d", g), po_m, 4'b0110);
         chk($sformatf("t5_gap%0d_valid", g), ov_m, 1'b1);
         drain;
      end
      // out_ready while empty does nothing, idle input holds state
      out_ready = 1'b1;
      idle(3);
      out_ready = 1'b0;
      chk("idle_valid", ov_m, 1'b0);
      chk("idle_po", po_m, 4'b0110);
`ifdef PARITY_CHECK_EN
      send_word(4'b1011, 1'b0, 1'b0);
      chk("t6_po", po_m, 4'b1011);
      chk("t6_perr_ok", pe_m, 1'b0);
      drain;
      pflip = 1'b1;
      send_word(4'b1011, 1'b0, 1'b0);
      pflip = 1'b0;
      chk("t6_po_bad", po_m, 4'b1011);
      chk("t6_perr_bad", pe_m, 1'b1);
      chk("t6_perr_bad_lsb", pe_l, 1'b1);
`else
      send_word(4'b1110, 1'b0, 1'b0);
      chk("t6_po_nopar", po_m, 4'b1110);
      chk("t6_perr_tied", pe_m, 1'b0);
`endif
      // reset mid-frame
      send(1'b1);
      send(1'b1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t6_rst_po", po_m, 4'h0);
      chk("t6_rst_valid", ov_m, 1'b0);
      chk("t6_rst_ovf", of_m, 1'b0);
      chk("t6_rst_perr", pe_m, 1'b0);
      send_word(4'b0101, 1'b0, 1'b0);
      chk("t6_after_rst", po_m, 4'b0101);
      chk("t6_after_rst_lsb", po_l, 4'b1010);
      chk("t6_after_rst_perr", pe_m, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
